// File: rtl/wb_stream_pkg.sv
// Shared register map, status layout and helpers for the Wishbone-to-stream sink.
package wb_stream_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int STAT_FULL_BIT  = 7;
  localparam int STAT_EMPTY_BIT = 6;
  localparam int STAT_CNT_W     = 5;
  localparam int FLUSH_BIT      = 0;

  typedef struct packed {
    logic                  full;
    logic                  empty;
    logic                  rsvd;
    logic [STAT_CNT_W-1:0] count;
  } status_t;

  function automatic status_t pack_status(input logic full, input logic empty,
                                          input logic [STAT_CNT_W-1:0] count);
    status_t s;
    s.full  = full;
    s.empty = empty;
    s.rsvd  = 1'b0;
    s.count = count;
    return s;
  endfunction

endpackage

// File: rtl/wb_ack_delay.sv
// Fixed-latency delay line for {valid, data} acknowledge responses.
// clr_i synchronously kills every response still in flight.
module wb_ack_delay #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic [WIDTH:0] in_w;
  logic [WIDTH:0] src_w  [LATENCY];
  logic [WIDTH:0] pipe_d [LATENCY];
  logic [WIDTH:0] pipe_q [LATENCY];

  // Data is zeroed alongside an invalid slot so the output reads 0 between acks.
  assign in_w = {vld_i, (vld_i ? dat_i : '0)};

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign src_w[g] = in_w;
    end else begin : g_rest
      assign src_w[g] = pipe_q[g-1];
    end
  end

  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      pipe_d[i] = clr_i ? '0 : src_w[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign vld_o = pipe_q[LATENCY-1][WIDTH];
  assign dat_o = pipe_q[LATENCY-1][WIDTH] ? pipe_q[LATENCY-1][WIDTH-1:0] : '0;

endmodule

// File: rtl/wb_stream_sink.sv
// Pipelined Wishbone responder that buffers written bytes and replays them
// as a valid/ready stream; a STATUS register reports fill level and flushes.
module wb_stream_sink
  import wb_stream_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int ACK_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic       adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       stall_o,
  output logic [7:0] tdata_o,
  output logic       tvalid_o,
  input  logic       tready_i
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [7:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic    req, accept, push, pop, flush;
  logic    full, empty;
  status_t status;
  logic [7:0] rdata;

  assign req   = cyc_i & stb_i;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Stall looks only at the registered count, so a same-cycle pop never unstalls.
  assign stall_o = req & we_i & (adr_i == REG_DATA) & full;
  assign accept  = req & ~stall_o;
  assign push    = accept & we_i & (adr_i == REG_DATA);
  assign flush   = accept & we_i & (adr_i == REG_STATUS) & dat_i[FLUSH_BIT];

  assign tvalid_o = ~empty;
  assign tdata_o  = mem_q[rd_ptr_q];
  assign pop      = tvalid_o & tready_i;

  assign status = pack_status(full, empty, STAT_CNT_W'(count_q));

  always_comb begin
    rdata = 8'h00;
    if (!we_i && adr_i == REG_STATUS) begin
      rdata = status;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    // Flush drops everything buffered and overrides any concurrent pop.
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dat_i;
    end
  end

  wb_ack_delay #(
    .LATENCY (ACK_LATENCY),
    .WIDTH   (8)
  ) u_ack_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (~cyc_i),
    .vld_i  (accept),
    .dat_i  (rdata),
    .vld_o  (ack_o),
    .dat_o  (dat_o)
  );

endmodule

// File: tb/tb_wb_stream_sink.sv
// Scoreboard bench for wb_stream_sink: three instances (ack latency 1, 3, 2)
// share one Wishbone/stream stimulus and are checked against per-instance queues.
module tb_wb_stream_sink;

  typedef struct {
    int         due;
    logic [7:0] data;
  } ack_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
  logic [7:0] wdat = 8'h00;
  logic       tready = 1'b0;

  logic [7:0] dat_o  [3];
  logic [7:0] tdata  [3];
  logic [2:0] ack_o, stall_o, tvalid;

  ack_t       aq [3][$];
  logic [7:0] sq [3][$];
  bit         pop_pend [3];

  int cyc_n  = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stream_sink #(.ADDR_WIDTH(4), .ACK_LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .dat_o(dat_o[0]), .ack_o(ack_o[0]), .stall_o(stall_o[0]),
    .tdata_o(tdata[0]), .tvalid_o(tvalid[0]), .tready_i(tready));

  wb_stream_sink #(.ADDR_WIDTH(4), .ACK_LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .dat_o(dat_o[1]), .ack_o(ack_o[1]), .stall_o(stall_o[1]),
    .tdata_o(tdata[1]), .tvalid_o(tvalid[1]), .tready_i(tready));

  wb_stream_sink #(.ADDR_WIDTH(4), .ACK_LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .dat_o(dat_o[2]), .ack_o(ack_o[2]), .stall_o(stall_o[2]),
    .tdata_o(tdata[2]), .tvalid_o(tvalid[2]), .tready_i(tready));

  function automatic int lat(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  function automatic void chk(input string nm, input int i,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got 'h%0h expected 'h%0h", nm, i, $time, act, exp);
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 3; i++) begin
      aq[i].delete();
      sq[i].delete();
      pop_pend[i] = 1'b0;
    end
  endfunction

  // Monitor: acks and stream outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        logic exp_ack;
        ack_t e;
        exp_ack = (aq[i].size() != 0) && (aq[i][0].due == cyc_n);
        chk("ack", i, 32'(ack_o[i]), 32'(exp_ack));
        if (exp_ack) begin
          e = aq[i].pop_front();
          chk("ack_data", i, 32'(dat_o[i]), 32'(e.data));
        end else begin
          chk("dat_idle", i, 32'(dat_o[i]), 32'h0);
        end
        chk("tvalid", i, 32'(tvalid[i]), 32'(sq[i].size() != 0));
        if (sq[i].size() != 0) begin
          chk("tdata", i, 32'(tdata[i]), 32'(sq[i][0]));
        end
        pop_pend[i] = tready && (sq[i].size() != 0);
      end
    end
  end

  always @(posedge clk) begin
    cyc_n++;
    for (int i = 0; i < 3; i++) begin
      if (pop_pend[i] && sq[i].size() != 0) void'(sq[i].pop_front());
      pop_pend[i] = 1'b0;
    end
  end

  task automatic xfer(input logic w, input logic a, input logic [7:0] d);
    int   n;
    int   sz;
    logic exp_stall;
    logic [7:0] rd;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    n = 0;
    forever begin
      @(negedge clk);
      exp_stall = w && (a == 1'b0) && (sq[0].size() == 16);
      for (int i = 0; i < 3; i++) chk("stall", i, 32'(stall_o[i]), 32'(exp_stall));
      if (!exp_stall) break;
      n++;
      if (n > 64) begin
        chk("stall_timeout", 0, 32'(n), 32'(64));
        #1 stb = 1'b0;
        return;
      end
    end
    sz = sq[0].size();
    rd = (w || !a) ? 8'h00 : {(sz == 16), (sz == 0), 1'b0, 5'(sz)};
    for (int i = 0; i < 3; i++) aq[i].push_back('{cyc_n + lat(i), rd});
    @(posedge clk);
    if (w && !a) for (int i = 0; i < 3; i++) sq[i].push_back(d);
    if (w && a && d[0]) for (int i = 0; i < 3; i++) sq[i].delete();
    #1 stb = 1'b0;
  endtask

  task automatic drop_cyc();
    ack_t keep [$];
    cyc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      keep.delete();
      foreach (aq[i][k]) if (aq[i][k].due <= cyc_n) keep.push_back(aq[i][k]);
      aq[i] = keep;
    end
  endtask

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ack", i, 32'(ack_o[i]), 32'h0);
      chk("rst_dat", i, 32'(dat_o[i]), 32'h0);
      chk("rst_tvalid", i, 32'(tvalid[i]), 32'h0);
      chk("rst_stall", i, 32'(stall_o[i]), 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream with acks still in flight.
    tready = 1'b0;
    xfer(1'b1, 1'b0, 8'h11);
    xfer(1'b1, 1'b0, 8'h22);
    xfer(1'b1, 1'b0, 8'h33);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_rst_tvalid", i, 32'(tvalid[i]), 32'h0);
      chk("async_rst_ack", i, 32'(ack_o[i]), 32'h0);
    end
    clear_model();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 1'b1, 8'h00);

    // Back-to-back writes streamed straight out, then a DATA read.
    tready = 1'b1;
    xfer(1'b1, 1'b0, 8'hA1);
    xfer(1'b1, 1'b0, 8'hB2);
    xfer(1'b0, 1'b0, 8'h00);
    repeat (4) @(posedge clk); #1;

    // Fill to 16, 17th write stalls until one pop.
    tready = 1'b0;
    for (int k = 0; k < 16; k++) xfer(1'b1, 1'b0, 8'(8'h40 + k));
    xfer(1'b0, 1'b1, 8'h00);
    fork
      xfer(1'b1, 1'b0, 8'hEE);
      begin
        repeat (3) @(posedge clk);
        #1 tready = 1'b1;
        @(posedge clk);
        #1 tready = 1'b0;
      end
    join
    xfer(1'b0, 1'b1, 8'h00);

    // Full: pop and push requested together, push waits one cycle.
    fork
      xfer(1'b1, 1'b0, 8'hF4);
      begin
        tready = 1'b1;
        @(posedge clk);
        #1 tready = 1'b0;
      end
    join
    xfer(1'b0, 1'b1, 8'h00);
    tready = 1'b1;
    repeat (20) @(posedge clk); #1;
    xfer(1'b0, 1'b1, 8'h00);

    // Non-flush STATUS write, then flush racing a pop.
    tready = 1'b0;
    for (int k = 0; k < 5; k++) xfer(1'b1, 1'b0, 8'(8'hC0 + k));
    xfer(1'b1, 1'b1, 8'hFE);
    xfer(1'b0, 1'b1, 8'h00);
    tready = 1'b1;
    xfer(1'b1, 1'b1, 8'h01);
    @(posedge clk); #1;
    xfer(1'b0, 1'b1, 8'h00);
    repeat (4) @(posedge clk); #1;

    // Abort the cycle right after an accept.
    xfer(1'b1, 1'b0, 8'h66);
    drop_cyc();
    repeat (5) @(posedge clk); #1;
    cyc = 1'b1;
    xfer(1'b0, 1'b1, 8'h00);

    repeat (10) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("acks_drained", i, 32'(aq[i].size()), 32'h0);
      chk("stream_drained", i, 32'(sq[i].size()), 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t: bench did not finish", $time);
    $fatal(1, "timeout");
  end

endmodule
